// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the 24-bit CPU.
// Presents PC to the combinational instruction memory, holds it MEM_LATENCY
// cycles, captures the returned word into a single-entry output register and
// hands it to decode over a valid/ready handshake. Supports branch redirect
// with flush and a sticky halt.
// Optional build macro FETCH_PERF_EN adds saturating FetchCount/StallCount ports.
module fetch_sequencer #(
    parameter logic [23:0] RESET_PC    = 24'd0,
    parameter logic [23:0] PC_STEP     = 24'd3,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        Halt,
    input  logic        BranchTaken,
    input  logic [23:0] BranchTarget,
    input  logic [23:0] MemInstruction,
    input  logic        InstrReady,
    output logic [23:0] PC,
    output logic [23:0] InstrOut,
    output logic [23:0] InstrPC,
    output logic        InstrValid,
    output logic        Halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HALTED
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [23:0] pc_nx, iout_nx, ipc_nx;
    logic        valid_nx;
    logic        capture, stall, xfer;

    assign Halted = (state == ST_HALTED);
    assign xfer   = InstrValid && InstrReady;

    // Next-state and next-register computation: Halt > BranchTaken > normal fetch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_nx    = PC;
        iout_nx  = InstrOut;
        ipc_nx   = InstrPC;
        valid_nx = InstrValid;
        capture  = 1'b0;
        stall    = 1'b0;
        if (state == ST_HALTED) begin
            valid_nx = 1'b0;
        end else if (Halt) begin
            state_nx = ST_HALTED;
            valid_nx = 1'b0;
        end else if (BranchTaken) begin
            pc_nx    = BranchTarget;
            valid_nx = 1'b0;
            cnt_nx   = '0;
            state_nx = Enable ? ST_WAIT : ST_IDLE;
        end else begin
            // Drain by default; a capture below overrides with a new valid word.
            if (xfer) valid_nx = 1'b0;
            if (state == ST_IDLE) begin
                if (Enable) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = '0;
                end
            end else if (!Enable) begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end else if (cnt != LAT_LAST) begin
                cnt_nx = cnt + 4'd1;
            end else if (!InstrValid || InstrReady) begin
                capture  = 1'b1;
                iout_nx  = MemInstruction;
                ipc_nx   = PC;
                valid_nx = 1'b1;
                pc_nx    = PC + PC_STEP;
                cnt_nx   = '0;
            end else begin
                stall = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            PC         <= RESET_PC;
            InstrOut   <= '0;
            InstrPC    <= '0;
            InstrValid <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            PC         <= pc_nx;
            InstrOut   <= iout_nx;
            InstrPC    <= ipc_nx;
            InstrValid <= valid_nx;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating capture and stall counters.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if (capture && FetchCount != '1) FetchCount <= FetchCount + 32'd1;
            if (stall && StallCount != '1)   StallCount <= StallCount + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = capture ^ stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: one instance at MEM_LATENCY=1
// (scoreboarded handshake stream) and one at MEM_LATENCY=3, driven from shared
// stimulus. Build with +define+FETCH_PERF_EN to also check the perf counters.
module tb_fetch_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        Halt = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [23:0] BranchTarget = '0;
    logic        InstrReady = 1'b1;

    logic [23:0] pc1, out1, ipc1, mem1;
    logic        v1, h1;
    logic [23:0] pc3, out3, ipc3, mem3;
    logic        v3, h3;
`ifdef FETCH_PERF_EN
    logic [31:0] fc1, sc1, fc3, sc3;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [23:0] sb[$];
    logic        sb_on = 1'b0;

    always #5 Clock = ~Clock;

    // Deterministic memory contents: bijective scramble of the address.
    function automatic logic [23:0] memword(input logic [23:0] a);
        return (a * 24'd40503) ^ 24'h5A3C96;
    endfunction

    assign mem1 = memword(pc1);
    assign mem3 = memword(pc3);

    fetch_sequencer #(.RESET_PC(24'd0), .PC_STEP(24'd3), .MEM_LATENCY(1)) u_lat1 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Halt(Halt),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .MemInstruction(mem1), .InstrReady(InstrReady),
        .PC(pc1), .InstrOut(out1), .InstrPC(ipc1), .InstrValid(v1), .Halted(h1)
`ifdef FETCH_PERF_EN
        , .FetchCount(fc1), .StallCount(sc1)
`endif
    );

    fetch_sequencer #(.RESET_PC(24'd0), .PC_STEP(24'd3), .MEM_LATENCY(3)) u_lat3 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Halt(Halt),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .MemInstruction(mem3), .InstrReady(InstrReady),
        .PC(pc3), .InstrOut(out3), .InstrPC(ipc3), .InstrValid(v3), .Halted(h3)
`ifdef FETCH_PERF_EN
        , .FetchCount(fc3), .StallCount(sc3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        check("sb_empty", sb.size(), 0);
        Reset        = 1'b1;
        Enable       = 1'b0;
        Halt         = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = '0;
        InstrReady   = 1'b1;
        sb.delete();
        tick();
        Reset = 1'b0;
    endtask

    // Scoreboard: every handshake transfer on the latency-1 instance pops one
    // expected fetch address and checks both the address and the word.
    always @(negedge Clock) begin
        if (sb_on && v1 && InstrReady) begin
            if (sb.size() == 0) begin
                check("sb_underflow", {8'h0, ipc1}, 32'hFFFFFFFF);
            end else begin
                logic [23:0] e;
                e = sb.pop_front();
                check("sb_ipc", {8'h0, ipc1}, {8'h0, e});
                check("sb_word", {8'h0, out1}, {8'h0, memword(e)});
            end
        end
    end

    initial begin
        // Reset values
        #2;
        check("rst_pc", {8'h0, pc1}, 32'd0);
        check("rst_out", {8'h0, out1}, 32'd0);
        check("rst_ipc", {8'h0, ipc1}, 32'd0);
        check("rst_valid", {31'd0, v1}, 32'd0);
        check("rst_halted", {31'd0, h1}, 32'd0);
        tick();
        Reset = 1'b0;

        // Streaming at one instruction per cycle
        sb_on = 1'b1;
        sb.push_back(24'd0);
        sb.push_back(24'd3);
        Enable = 1'b1;
        tick(); check("s1_pc0", {8'h0, pc1}, 32'd0); check("s1_v0", {31'd0, v1}, 32'd0);
        tick(); check("s1_pc3", {8'h0, pc1}, 32'd3); check("s1_v1", {31'd0, v1}, 32'd1);
                check("s1_ipc0", {8'h0, ipc1}, 32'd0);
        tick(); check("s1_pc6", {8'h0, pc1}, 32'd6); check("s1_ipc3", {8'h0, ipc1}, 32'd3);
        tick(); check("s1_pc9", {8'h0, pc1}, 32'd9); check("s1_ipc6", {8'h0, ipc1}, 32'd6);

        // Back-pressure stall for four cycles
        do_reset();
        sb.push_back(24'd0);
        InstrReady = 1'b0;
        Enable = 1'b1;
        tick();
        tick(); check("s2_v", {31'd0, v1}, 32'd1); check("s2_pc", {8'h0, pc1}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s2_hold_ipc", {8'h0, ipc1}, 32'd0);
            check("s2_hold_out", {8'h0, out1}, {8'h0, memword(24'd0)});
            check("s2_hold_pc", {8'h0, pc1}, 32'd3);
            check("s2_hold_v", {31'd0, v1}, 32'd1);
        end
`ifdef FETCH_PERF_EN
        check("s2_stallcnt", sc1, 32'd4);
        check("s2_fetchcnt", fc1, 32'd1);
`endif
        InstrReady = 1'b1;
        tick(); check("s2_resume_pc", {8'h0, pc1}, 32'd6); check("s2_resume_ipc", {8'h0, ipc1}, 32'd3);

        // Branch redirect flushes the pending word
        do_reset();
        Enable = 1'b1;
        tick();
        tick(); check("s3_v", {31'd0, v1}, 32'd1);
        BranchTaken  = 1'b1;
        BranchTarget = 24'd13;
        InstrReady   = 1'b0;
        sb.push_back(24'd13);
        tick(); check("s3_flush", {31'd0, v1}, 32'd0); check("s3_pc", {8'h0, pc1}, 32'd13);
        BranchTaken = 1'b0;
        InstrReady  = 1'b1;
        tick(); check("s3_ipc", {8'h0, ipc1}, 32'd13); check("s3_pc16", {8'h0, pc1}, 32'd16);
        tick(); check("s3_pc19", {8'h0, pc1}, 32'd19);

        // PC wrap with MEM_LATENCY=3
        do_reset();
        sb_on = 1'b0;
        Enable       = 1'b1;
        BranchTaken  = 1'b1;
        BranchTarget = 24'hFFFFFE;
        tick(); check("s4_pc_a", {8'h0, pc3}, 32'h00FFFFFE);
        BranchTaken = 1'b0;
        tick(); check("s4_pc_b", {8'h0, pc3}, 32'h00FFFFFE); check("s4_v", {31'd0, v3}, 32'd0);
        tick(); check("s4_pc_c", {8'h0, pc3}, 32'h00FFFFFE);
        tick(); check("s4_wrap", {8'h0, pc3}, 32'h00000001);
                check("s4_ipc", {8'h0, ipc3}, 32'h00FFFFFE);
                check("s4_word", {8'h0, out3}, {8'h0, memword(24'hFFFFFE)});
                check("s4_v3", {31'd0, v3}, 32'd1);

        // Halt wins over a simultaneous branch and is sticky
        do_reset();
        Enable     = 1'b1;
        InstrReady = 1'b0;
        tick();
        tick(); check("s5_pre_pc", {8'h0, pc1}, 32'd3);
        Halt         = 1'b1;
        BranchTaken  = 1'b1;
        BranchTarget = 24'd13;
        tick();
        check("s5_halted", {31'd0, h1}, 32'd1);
        check("s5_v", {31'd0, v1}, 32'd0);
        check("s5_pc", {8'h0, pc1}, 32'd3);
        Halt = 1'b0;
        InstrReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s5_hold_h", {31'd0, h1}, 32'd1);
            check("s5_hold_v", {31'd0, v1}, 32'd0);
            check("s5_hold_pc", {8'h0, pc1}, 32'd3);
        end
`ifdef FETCH_PERF_EN
        check("s5_fetchcnt", fc1, 32'd1);
`endif
        BranchTaken = 1'b0;

        // Asynchronous reset mid-WAIT on the latency-3 instance
        do_reset();
        Enable = 1'b1;
        tick();
        tick();
        tick();
        tick(); check("s6_cap_v", {31'd0, v3}, 32'd1); check("s6_cap_pc", {8'h0, pc3}, 32'd3);
        InstrReady = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        check("s6_async_pc", {8'h0, pc3}, 32'd0);
        check("s6_async_out", {8'h0, out3}, 32'd0);
        check("s6_async_ipc", {8'h0, ipc3}, 32'd0);
        check("s6_async_v", {31'd0, v3}, 32'd0);
        check("s6_async_h", {31'd0, h3}, 32'd0);
        tick();
        Reset = 1'b0;
        InstrReady = 1'b1;
        tick(); check("s6_res_pc0", {8'h0, pc3}, 32'd0);
        tick();
        tick(); check("s6_res_v0", {31'd0, v3}, 32'd0);
        tick(); check("s6_res_v", {31'd0, v3}, 32'd1);
                check("s6_res_ipc", {8'h0, ipc3}, 32'd0);
                check("s6_res_pc3", {8'h0, pc3}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
